collect_2x1_cmd_flow_seq: RTL
=============================

COLLECT_2X1_CMD_FLOW_SEQ -- requirements
Module: collect_2x1_cmd_flow_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 32: payload width per port.
REQ-002 Parameter DESTINATION_TAG_WIDTH, default 1: width of the source tag prepended per merge stage.
REQ-003 Parameter IN_COMMAND_WIDTH, default 1: command width per input port.
REQ-004 Parameter FIFO_DEPTH, default 2: entries per input queue; power of two, at least 2.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  clock; all state changes on the rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 i_valid  input  2  per-input valid; bit 1 is the high input, bit 0 is the low input.
REQ-009 i_data_bus  input  2*DATA_WIDTH  high payload in [2*DATA_WIDTH-1:DATA_WIDTH], low payload in [DATA_WIDTH-1:0].
REQ-010 i_cmd  input  2*IN_COMMAND_WIDTH  per-input command, split into high and low halves in the same way as i_data_bus.
REQ-011 o_full  output  2  per-input queue full; registered.
REQ-012 i_en  input  1  output stage enable; 0 stalls the output.
REQ-013 o_valid  output  1  merged output valid.
REQ-014 o_data_bus  output  DATA_WIDTH  merged payload.
REQ-015 o_cmd  output  IN_COMMAND_WIDTH+DESTINATION_TAG_WIDTH  {source tag, forwarded command}; tag 1 = high input, tag 0 = low input.

Function
REQ-016 The block SHALL push an input when i_valid[k]=1 and o_full[k]=0; pushes are independent of i_en.
REQ-017 When i_valid[k]=1 and o_full[k]=1, the block SHALL drop the beat and leave the queue contents unchanged.
REQ-018 o_full[k] SHALL equal (count[k]==FIFO_DEPTH), computed from the registered count. A pop in the same cycle SHALL NOT admit a push into a full queue.
REQ-019 When i_en=1 and at least one queue is non-empty, the block SHALL pop exactly one entry and register it to the output, with o_valid=1 on the following cycle.
REQ-020 Arbitration SHALL be round-robin with a 1-bit priority pointer. When both queues are non-empty, the input named by the pointer is granted; after any grant, the pointer points to the other input.
REQ-021 When only one queue is non-empty, that queue SHALL be granted and the pointer SHALL be updated as in REQ-020.
REQ-022 When i_en=1 and both queues are empty, the next-cycle outputs SHALL be o_valid=0, o_data_bus=0 and o_cmd=0.
REQ-023 When i_en=0, the block SHALL perform no pop, hold o_valid, o_data_bus and o_cmd, and hold the pointer.
REQ-024 Minimum latency SHALL be 2 cycles: push at edge N, pop at edge N+1, output visible after edge N+1.
REQ-025 Queue read and write pointers SHALL wrap modulo FIFO_DEPTH. Count SHALL be updated as +1 for push only, -1 for pop only, and unchanged for a simultaneous push and pop.
REQ-026 Output order within one input SHALL be FIFO order; no reordering.

Reset
REQ-027 On rst_n=0, the block SHALL asynchronously clear both queues (count, read pointer and write pointer = 0), set the priority pointer to 0 (low input), and set o_valid=0, o_data_bus=0, o_cmd=0 and o_full=2'b00.
REQ-028 Reset asserted mid-operation SHALL discard all queued beats; none SHALL appear after reset deassertion.

Configuration
REQ-029 Macro COLLECT_2X1_DROP_COUNT_EN: when defined, the block SHALL add the output o_drop_cnt [7:0], which increments once per dropped beat per input and saturates at 255. Two simultaneous drops SHALL add 2. o_drop_cnt SHALL reset to 0.
REQ-030 Without COLLECT_2X1_DROP_COUNT_EN, there SHALL be no o_drop_cnt port and no counter logic; drop behaviour is otherwise unchanged.

Structure
REQ-031 Tag constants (TAG_HIGH=1, TAG_LOW=0) and the output-command-width function SHALL live in the shared NoC package.
REQ-032 Each input queue SHALL be one instance of a sub-module sync_fifo_cmd_data that stores {cmd, data}; there SHALL be two instances.

Verification
REQ-033 Single low beat: i_valid=01, low data=AAAAAAAA, cmd=0, i_en=1 -> two cycles later, o_valid=1, o_data_bus=AAAAAAAA, o_cmd=2'b00.
REQ-034 Simultaneous high and low beats: high=BBBBBBBB, low=AAAAAAAA after reset -> low is output first with o_cmd tag 0, high follows on the next cycle with tag 1.
REQ-035 Stall: fill both queues with i_en=0 -> o_full=11, output held. A third beat on the low input is dropped (o_drop_cnt=1 with the macro defined). With i_en=1 -> 4 beats in alternating L,H,L,H order, then o_valid=0 with zero outputs.
REQ-036 Reset mid-stream: assert rst_n=0 with 3 beats queued -> all outputs and o_full are 0 immediately; after release with no input, o_valid stays 0.
REQ-037 Saturation: with the macro defined, 300 drops on the low input -> o_drop_cnt=255.

Source files
------------

// File: rtl/collect_2x1_cmd_flow_seq_pkg.sv
// Shared NoC constants for the 2:1 command collector: source tags and the merged command width.
// No latency (constants and pure function); no backpressure.
// Optional drop counter is enabled by COLLECT_2X1_DROP_COUNT_EN in the top module.
package collect_2x1_cmd_flow_seq_pkg;

  localparam int TAG_HIGH = 1;
  localparam int TAG_LOW  = 0;

  function automatic int out_cmd_width(input int cmd_w, input int tag_w);
    return cmd_w + tag_w;
  endfunction

endpackage

// File: rtl/sync_fifo_cmd_data.sv
// Single-clock queue holding {cmd, data} entries; head is presented combinationally.
// Zero read latency; push while full is ignored, so the caller owns drop decisions.
// Full/empty derive from the registered occupancy count only.
module sync_fifo_cmd_data #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = 1;
  localparam logic [AW:0]   CNT_ONE   = 1;
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_DEPTH);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end

  // Storage needs no reset: nothing is read until the count says it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/collect_2x1_cmd_flow_seq.sv
// Merges two queued {cmd, data} inputs into one tagged output stream with round-robin arbitration.
// Latency 2 cycles (push, then pop into the output register); i_en=0 holds the output and stops pops.
// Beats arriving at a full queue are dropped; COLLECT_2X1_DROP_COUNT_EN adds a saturating drop counter.
module collect_2x1_cmd_flow_seq
  import collect_2x1_cmd_flow_seq_pkg::*;
#(
  parameter int DATA_WIDTH            = 32,
  parameter int DESTINATION_TAG_WIDTH = 1,
  parameter int IN_COMMAND_WIDTH      = 1,
  parameter int FIFO_DEPTH            = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    i_valid,
  input  logic [2*DATA_WIDTH-1:0]       i_data_bus,
  input  logic [2*IN_COMMAND_WIDTH-1:0] i_cmd,
  output logic [1:0]                    o_full,
  input  logic                          i_en,
  output logic                          o_valid,
  output logic [DATA_WIDTH-1:0]         o_data_bus,
  output logic [out_cmd_width(IN_COMMAND_WIDTH, DESTINATION_TAG_WIDTH)-1:0] o_cmd
`ifdef COLLECT_2X1_DROP_COUNT_EN
  ,
  output logic [7:0]                    o_drop_cnt
`endif
);

  localparam int EW = IN_COMMAND_WIDTH + DATA_WIDTH;

  logic [1:0]    push, pop, empty, full;
  logic [EW-1:0] head [2];
  logic          prio, sel_hi;

  sync_fifo_cmd_data #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo_lo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push[0]),
    .push_dat ({i_cmd[IN_COMMAND_WIDTH-1:0], i_data_bus[DATA_WIDTH-1:0]}),
    .pop      (pop[0]),
    .pop_dat  (head[0]),
    .empty    (empty[0]),
    .full     (full[0])
  );

  sync_fifo_cmd_data #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo_hi (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push[1]),
    .push_dat ({i_cmd[2*IN_COMMAND_WIDTH-1:IN_COMMAND_WIDTH], i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH]}),
    .pop      (pop[1]),
    .pop_dat  (head[1]),
    .empty    (empty[1]),
    .full     (full[1])
  );

  // Full comes from the pre-edge count, so a same-cycle pop never frees room for a push.
  assign o_full = full;
  assign push   = i_valid & ~full;

  always_comb begin
    sel_hi = !empty[1] && (empty[0] || prio);
    pop    = 2'b00;
    if (i_en && !(&empty)) pop = sel_hi ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio       <= 1'b0;
      o_valid    <= 1'b0;
      o_data_bus <= '0;
      o_cmd      <= '0;
    end else if (i_en) begin
      if (pop[1]) begin
        prio       <= 1'b0;
        o_valid    <= 1'b1;
        o_data_bus <= head[1][DATA_WIDTH-1:0];
        o_cmd      <= {DESTINATION_TAG_WIDTH'(TAG_HIGH), head[1][EW-1:DATA_WIDTH]};
      end else if (pop[0]) begin
        prio       <= 1'b1;
        o_valid    <= 1'b1;
        o_data_bus <= head[0][DATA_WIDTH-1:0];
        o_cmd      <= {DESTINATION_TAG_WIDTH'(TAG_LOW), head[0][EW-1:DATA_WIDTH]};
      end else begin
        o_valid    <= 1'b0;
        o_data_bus <= '0;
        o_cmd      <= '0;
      end
    end
  end

`ifdef COLLECT_2X1_DROP_COUNT_EN
  logic [1:0] drop;
  logic [8:0] drop_sum;

  assign drop     = i_valid & full;
  assign drop_sum = {1'b0, o_drop_cnt} + 9'(drop[0]) + 9'(drop[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_drop_cnt <= '0;
    else        o_drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end
`endif

endmodule
